// File: rtl/uncached_write_buffer_pkg.sv
// uncached_write_buffer_pkg: drain FSM encoding and queued store entry layout shared by the buffer, its FIFO and the bus interface
package uncached_write_buffer_pkg;
    localparam int SIZE_W = 2;
    localparam int STRB_W = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ENTRY_W = SIZE_W + STRB_W + ADDR_W + DATA_W;
    typedef enum logic [1:0] {IDLE, W_ADDR, W_DATA, R_DATA} state_e;
    typedef struct packed {
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;
endpackage

// File: rtl/uncached_write_buffer_if.sv
// uncached_write_buffer_if: sram-like request bus; master drives req/wr/size/wstrb/addr/wdata, slave answers addr_ok/data_ok/rdata
interface uncached_write_buffer_if;
    import uncached_write_buffer_pkg::*;
    logic              req;
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;
    modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/uncached_write_buffer_sync_fifo.sv
// uncached_write_buffer_sync_fifo: DEPTH-entry store queue; ports clk/reset, push+din at tail, pop/dout at head (combinational read), empty/full/count
module uncached_write_buffer_sync_fifo
    import uncached_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   din,
    output entry_t                   dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    entry_t        mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    always_comb begin
        head_d  = pop ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        dout    = mem_q[head_q];
        empty   = count_q == '0;
        full    = count_q == (AW+1)'(DEPTH);
        count   = count_q;
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= din;
        head_q  <= reset ? '0 : head_d;
        tail_q  <= reset ? '0 : tail_d;
        count_q <= reset ? '0 : count_d;
    end
endmodule

// File: rtl/uncached_write_buffer.sv
// uncached_write_buffer: posts uncached CPU stores into a FIFO and drains them one at a time; reads wait for an empty buffer and pass through
// ports: clk, reset (sync, active high), u = CPU-side sram-like slave, d = bridge-side sram-like master
module uncached_write_buffer
    import uncached_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    uncached_write_buffer_if.slave  u,
    uncached_write_buffer_if.master d
);
    localparam int AW = $clog2(DEPTH);
    state_e      state_q, state_d;
    logic        wack_q, wack_d, rst_q, rst_d;
    logic        blk, mirror, rd_ok, push, pop, empty, full;
    logic [AW:0] count;
    entry_t      head;
    uncached_write_buffer_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .din('{size: u.size, wstrb: u.wstrb, addr: u.addr, wdata: u.wdata}),
        .dout(head), .empty(empty), .full(full), .count(count)
    );
    always_comb begin
        // rst_q keeps both sides quiet for the cycle following reset as well
        rst_d     = reset;
        blk       = reset | rst_q;
        rd_ok     = empty & (state_q == IDLE) & ~wack_q & d.addr_ok;
        u.addr_ok = ~blk & (u.wr ? ~full : rd_ok);
        push      = u.req & u.wr & u.addr_ok;
        pop       = (state_q == W_DATA) & d.data_ok;
        wack_d    = push;
        u.data_ok = ~blk & (wack_q | ((state_q == R_DATA) & d.data_ok));
        u.rdata   = (~blk & (state_q == R_DATA) & d.data_ok) ? d.rdata : '0;
        // reads pass straight through; a pending write ack also holds the read off downstream so no unanswered read is issued
        mirror    = (state_q == IDLE) & empty;
        d.req     = ~blk & (mirror ? u.req & ~u.wr & ~wack_q : state_q == W_ADDR);
        d.wr      = mirror ? u.wr : 1'b1;
        d.size    = mirror ? u.size : head.size;
        d.wstrb   = mirror ? u.wstrb : head.wstrb;
        d.addr    = mirror ? u.addr : head.addr;
        d.wdata   = mirror ? u.wdata : head.wdata;
        state_d   = state_q;
        unique case (state_q)
            IDLE:   state_d = !empty ? W_ADDR : (u.req & ~u.wr & u.addr_ok) ? R_DATA : IDLE;
            W_ADDR: state_d = d.addr_ok ? W_DATA : W_ADDR;
            W_DATA: state_d = !d.data_ok ? W_DATA : (count != (AW+1)'(1) || push) ? W_ADDR : IDLE;
            R_DATA: state_d = d.data_ok ? IDLE : R_DATA;
        endcase
    end
    always_ff @(posedge clk) begin
        rst_q   <= rst_d;
        state_q <= reset ? IDLE : state_d;
        wack_q  <= reset ? 1'b0 : wack_d;
    end
endmodule

// File: doc/uncached_write_buffer.md
UNCACHED_WRITE_BUFFER -- requirements
Module: uncached_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queued store entries (power of two, 2..16).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 u_req / u_wr / u_size[1:0] / u_wstrb[3:0] / u_addr[31:0] / u_wdata[31:0]  in  CPU-side uncached data request (sram-like).
REQ-005 u_addr_ok  out  1  request accepted this cycle; u_data_ok  out  1  transaction complete; u_rdata  out  32  read data, valid with u_data_ok.
REQ-006 d_req / d_wr / d_size[1:0] / d_wstrb[3:0] / d_addr[31:0] / d_wdata[31:0]  out  request toward the AXI bridge uncached data port.
REQ-007 d_addr_ok  in  1  bridge accepted; d_data_ok  in  1  bridge completed; d_rdata  in  32  bridge read data.

Function
REQ-008 A handshake SHALL occur on either side when req and addr_ok are both 1 in the same cycle.
REQ-009 u_addr_ok for a write (u_wr=1) SHALL be 1 exactly when the FIFO is not full; a pop in the same cycle SHALL NOT free a slot for that cycle's push.
REQ-010 An accepted write SHALL be pushed (size, wstrb, addr, wdata) at the tail, and u_data_ok SHALL pulse 1 in the following cycle with u_rdata=0.
REQ-011 u_addr_ok for a read (u_wr=0) SHALL be 1 only when the FIFO is empty, the FSM is IDLE, no write ack is pending, and d_addr_ok=1.
REQ-012 The drain FSM SHALL have states IDLE, W_ADDR, W_DATA, R_DATA.
REQ-013 IDLE -> W_ADDR when the FIFO is non-empty; IDLE -> R_DATA on an upstream read handshake; otherwise remain.
REQ-014 In W_ADDR, d_req=1 and d_wr=1 with head-entry fields; -> W_DATA on d_addr_ok.
REQ-015 In W_DATA, d_req=0; on d_data_ok the head SHALL be popped, -> W_ADDR if entries remain, else IDLE.
REQ-016 In IDLE with the FIFO empty, d_req SHALL mirror u_req&~u_wr and d_* fields SHALL mirror u_*, combinationally.
REQ-017 In R_DATA, d_req=0; on d_data_ok, u_data_ok=1 and u_rdata=d_rdata in that same cycle, -> IDLE.
REQ-018 Writes SHALL drain in acceptance order; at most one downstream transaction SHALL be outstanding.
REQ-019 A read SHALL never pass a buffered write (ordering by drain-before-read, no address compare).
REQ-020 Head/tail pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 d_req SHALL stay asserted with stable fields in W_ADDR until d_addr_ok.
REQ-023 d_addr_ok, d_data_ok outside W_ADDR/W_DATA/IDLE-read/R_DATA SHALL be ignored.

Reset
REQ-024 Reset SHALL force FSM=IDLE, pointers=0, count=0, pending write ack=0.
REQ-025 During and one cycle after reset, u_addr_ok, u_data_ok, d_req SHALL be 0; u_rdata SHALL be 0.
REQ-026 Reset mid-operation SHALL discard all buffered entries and any outstanding transaction without a response.

Structure
REQ-027 FSM state encoding and the entry field widths SHALL reside in the shared CPU package.
REQ-028 Storage SHALL be one sub-module, sync_fifo (DEPTH x 70-bit entry: size, wstrb, addr, wdata; registered memory, combinational head read).

Verification
REQ-029 Three back-to-back writes to 0xBFAF_F000/4/8, d_addr_ok=1, d_data_ok 2 cycles later -> u_data_ok each next cycle; d_* emits the three in order.
REQ-030 DEPTH=4, d_addr_ok=0, five writes -> four accepted, fifth sees u_addr_ok=0 until first W_DATA pop.
REQ-031 Write 0x1234_5678 to 0xBFD0_F010 then read 0xBFD0_F010 -> read d_req only after write d_data_ok; u_rdata=d_rdata with u_data_ok.
REQ-032 Read on empty FIFO, d_rdata=0xDEAD_BEEF 3 cycles later -> u_data_ok one pulse, u_rdata=0xDEAD_BEEF, FSM IDLE next cycle.
REQ-033 Fill 4, drain 2, push 3 more -> pointer wrap; all seven writes drained in order, count returns to 0.
REQ-034 Assert reset while in W_DATA with 2 entries -> next cycle count=0, d_req=0, no u_data_ok pulses.
